wb_burst_master: RTL and testbench

WB_BURST_MASTER -- requirements
Module: wb_burst_master

---
 rtl/wb_burst_master.sv | 162 ++++++++++++++++
 tb/tb_wb_burst_master.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_master.sv
// Wishbone incrementing-burst master: one command moves cmd_len beats, each write beat
// pulled from the wdata stream and each read beat pushed to rdata, with an ack timeout.
module wb_burst_master #(
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int BLW = 5,
    parameter int TO  = 256
) (
    input  logic              sys_clk,
    input  logic              RESETN,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [BLW-1:0]    cmd_len,

    input  logic [DW-1:0]     wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,

    output logic [DW-1:0]     rdata,
    output logic              rdata_valid,

    output logic              done,
    output logic              err,

    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [AW-1:0]     wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i
);

    localparam int              TW       = $clog2(TO + 1);
    localparam logic [AW-1:0]   STEP     = AW'(DW / 8);
    localparam logic [2:0]      CTI_INCR = 3'b010;
    localparam logic [2:0]      CTI_END  = 3'b111;

    typedef enum logic [1:0] {IDLE, LOAD, BUS, DONE} state_t;

    state_t          state;
    logic [BLW-1:0]  remaining;
    logic [TW-1:0]   timer;
    logic            timed_out;

    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            state       <= IDLE;
            remaining   <= '0;
            timer       <= '0;
            timed_out   <= 1'b0;
            cmd_ready   <= 1'b0;
            wdata_ready <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_addr_o   <= '0;
            wb_dat_o    <= '0;
            wb_sel_o    <= '0;
            wb_cti_o    <= 3'b000;
        end else begin
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            case (state)
                IDLE: begin
                    timer     <= '0;
                    timed_out <= 1'b0;
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        wb_we_o   <= cmd_we;
                        wb_addr_o <= cmd_addr;
                        remaining <= cmd_len;
                        if (cmd_len == '0) begin
                            state <= DONE;
                        end else if (cmd_we) begin
                            state       <= LOAD;
                            wb_cyc_o    <= 1'b1;
                            wdata_ready <= 1'b1;
                        end else begin
                            state    <= BUS;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_sel_o <= '1;
                            wb_cti_o <= (cmd_len == BLW'(1)) ? CTI_END : CTI_INCR;
                        end
                    end
                end

                LOAD: begin
                    timer <= '0;
                    if (wdata_valid) begin
                        state       <= BUS;
                        wb_dat_o    <= wdata;
                        wdata_ready <= 1'b0;
                        wb_stb_o    <= 1'b1;
                        wb_sel_o    <= '1;
                        wb_cti_o    <= (remaining == BLW'(1)) ? CTI_END : CTI_INCR;
                    end
                end

                BUS: begin
                    if (wb_ack_i) begin
                        timer     <= '0;
                        remaining <= remaining - 1'b1;
                        wb_addr_o <= wb_addr_o + STEP;
                        if (!wb_we_o) begin
                            rdata       <= wb_dat_i;
                            rdata_valid <= 1'b1;
                        end
                        if (remaining == BLW'(1)) begin
                            state    <= DONE;
                            wb_cyc_o <= 1'b0;
                            wb_stb_o <= 1'b0;
                            wb_sel_o <= '0;
                            wb_cti_o <= 3'b000;
                        end else if (wb_we_o) begin
                            // cyc stays up across the write-data gap; only stb drops
                            state       <= LOAD;
                            wb_stb_o    <= 1'b0;
                            wb_sel_o    <= '0;
                            wdata_ready <= 1'b1;
                        end else begin
                            wb_cti_o <= (remaining == BLW'(2)) ? CTI_END : CTI_INCR;
                        end
                    end else if (timer == TW'(TO - 1)) begin
                        state     <= DONE;
                        timed_out <= 1'b1;
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_sel_o  <= '0;
                        wb_cti_o  <= 3'b000;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                DONE: begin
                    timer     <= '0;
                    done      <= 1'b1;
                    err       <= timed_out;
                    timed_out <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboarded bench for wb_burst_master: cycle-stepped slave and write-data feeder
// sampled on the falling edge, expected beats and read data queued up front.
module tb_wb_burst_master;

    logic        sys_clk = 1'b0;
    logic        RESETN;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr;
    logic [4:0]  cmd_len;
    logic [31:0] wdata;
    logic        wdata_valid, wdata_ready;
    logic [31:0] rdata;
    logic        rdata_valid, done, err;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_addr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;

    always #5 sys_clk = ~sys_clk;

    wb_burst_master #(.DW(32), .AW(32), .BLW(5), .TO(256)) dut (
        .sys_clk(sys_clk), .RESETN(RESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err(err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
    );

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  cti;
        logic [31:0] dat;
    } beat_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_rdata[$];
    logic [31:0] rd_src[$];
    logic [31:0] wr_src[$];

    int vectors = 0;
    int miscompares = 0;

    int r_done, r_done_at, r_err, r_err_done, r_viol, r_stb, r_cyc, r_load, r_rdv;

    // Issues one command and steps the bus until done (plus two cycles) or budget expiry.
    task automatic run_cmd(input logic we, input logic [31:0] addr, input logic [4:0] len,
                           input int gap, input int lat, input bit ack_on, input int budget);
        int age, wr_wait, wi, acks, waited;
        bit started;
        logic [31:0] s_addr, s_dat, er;
        logic [2:0]  s_cti;
        beat_t b;
        r_done = 0; r_done_at = -1; r_err = 0; r_err_done = 0; r_viol = 0;
        r_stb = 0; r_cyc = 0; r_load = 0; r_rdv = 0;
        age = 0; wr_wait = 0; wi = 0; acks = 0; started = 0; waited = 0;
        s_addr = '0; s_dat = '0; s_cti = '0;
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len;
        while (!cmd_ready && waited < 50) begin
            @(negedge sys_clk);
            waited++;
        end
        vectors++;
        if (!cmd_ready) begin
            miscompares++;
            $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, want 1", cmd_ready, waited);
            cmd_valid = 1'b0;
            return;
        end
        for (int t = 1; t <= budget; t++) begin
            @(negedge sys_clk);
            if (t == 1) cmd_valid = 1'b0;
            if (wb_ack_i) begin
                wb_ack_i = 1'b0;
                age = 0;
            end
            if (done) begin
                r_done++;
                if (r_done_at < 0) r_done_at = t;
                if (err) r_err_done++;
            end
            if (err) r_err++;
            if (wb_cyc_o) r_cyc++;
            if (wb_cyc_o && !wb_stb_o) r_load++;
            if (rdata_valid) begin
                r_rdv++;
                vectors++;
                if (exp_rdata.size() == 0) begin
                    miscompares++;
                    $display("FAIL rdata_extra: got %h, none expected", rdata);
                end else begin
                    er = exp_rdata.pop_front();
                    if (rdata !== er) begin
                        miscompares++;
                        $display("FAIL rdata: got %h, want %h", rdata, er);
                    end
                end
            end
            if (wdata_valid && !wdata_ready) begin
                wdata_valid = 1'b0;
                wi++;
                wr_wait = 0;
                if (wr_src.size() > 0) void'(wr_src.pop_front());
            end
            if (wdata_ready && !wdata_valid) begin
                if (wi == 0 || wr_wait >= gap) begin
                    wdata_valid = 1'b1;
                    wdata = (wr_src.size() > 0) ? wr_src[0] : 32'h0;
                end else begin
                    wr_wait++;
                end
            end
            if (ack_on && started && acks < int'(len) && !wb_cyc_o) r_viol++;
            if (wb_stb_o) begin
                started = 1'b1;
                r_stb++;
                if (age == 0) begin
                    s_addr = wb_addr_o; s_dat = wb_dat_o; s_cti = wb_cti_o;
                end else if (wb_addr_o !== s_addr || wb_dat_o !== s_dat || wb_cti_o !== s_cti) begin
                    r_viol++;
                end
                if (ack_on && age == lat) begin
                    vectors++;
                    if (exp_beats.size() == 0) begin
                        miscompares++;
                        $display("FAIL beat_extra: got addr %h, none expected", wb_addr_o);
                    end else begin
                        b = exp_beats.pop_front();
                        if ({wb_addr_o, wb_cti_o, wb_we_o, wb_sel_o, wb_cyc_o} !== {b.addr, b.cti, we, 4'hF, 1'b1}) begin
                            miscompares++;
                            $display("FAIL beat_ctrl: got addr %h cti %b we %b sel %h cyc %b, want addr %h cti %b we %b sel f cyc 1",
                                     wb_addr_o, wb_cti_o, wb_we_o, wb_sel_o, wb_cyc_o, b.addr, b.cti, we);
                        end
                        if (we && wb_dat_o !== b.dat) begin
                            miscompares++;
                            $display("FAIL beat_wdata: got %h, want %h", wb_dat_o, b.dat);
                        end
                    end
                    wb_ack_i = 1'b1;
                    wb_dat_i = (rd_src.size() > 0) ? rd_src.pop_front() : 32'hDEAD_BEEF;
                    acks++;
                end
                age++;
            end else begin
                age = 0;
            end
            if (r_done_at >= 0 && t >= r_done_at + 2) break;
        end
        wdata_valid = 1'b0;
        vectors++;
        if (r_done_at < 0) begin
            miscompares++;
            $display("FAIL done_timeout: no done within %0d cycles, want one", budget);
        end
    endtask

    task automatic check_end(input string name, input int want_done, input int want_err);
        vectors++;
        if (r_done != want_done || r_err != want_err || r_viol != 0 ||
            exp_beats.size() != 0 || exp_rdata.size() != 0) begin
            miscompares++;
            $display("FAIL %s_end: got done %0d err %0d viol %0d beats_left %0d rdata_left %0d, want %0d %0d 0 0 0",
                     name, r_done, r_err, r_viol, exp_beats.size(), exp_rdata.size(), want_done, want_err);
        end
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata = '0; wdata_valid = 1'b0; wb_ack_i = 1'b0; wb_dat_i = '0;
        repeat (3) @(negedge sys_clk);
        vectors++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wdata_ready, rdata_valid, done, err, cmd_ready} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, want 00000000",
                     {wb_cyc_o, wb_stb_o, wb_we_o, wdata_ready, rdata_valid, done, err, cmd_ready});
        end
        vectors++;
        if ({wb_addr_o, wb_dat_o, rdata} !== 96'h0 || wb_cti_o !== 3'b000 || wb_sel_o !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_data: got addr %h dat %h rdata %h cti %b sel %h, want all 0",
                     wb_addr_o, wb_dat_o, rdata, wb_cti_o, wb_sel_o);
        end
        RESETN = 1'b1;
        @(negedge sys_clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b, want 1", cmd_ready);
        end
    endtask

    task automatic test_ack_ignored();
        int rdv_seen = 0;
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h5555_AAAA;
        repeat (3) begin
            @(negedge sys_clk);
            if (rdata_valid || wb_cyc_o || done) rdv_seen++;
        end
        wb_ack_i = 1'b0;
        vectors++;
        if (rdv_seen != 0) begin
            miscompares++;
            $display("FAIL idle_ack: got %0d active cycles, want 0", rdv_seen);
        end
    endtask

    task automatic test_write_burst();
        for (int i = 0; i < 4; i++) begin
            exp_beats.push_back('{32'h100 + 32'(4 * i), (i == 3) ? 3'b111 : 3'b010, 32'hA0 + 32'(i)});
            wr_src.push_back(32'hA0 + 32'(i));
        end
        run_cmd(1'b1, 32'h100, 5'd4, 0, 1, 1'b1, 100);
        check_end("write4", 1, 0);
    endtask

    task automatic test_read_burst();
        logic [31:0] vals[3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            exp_beats.push_back('{32'h200 + 32'(4 * i), (i == 2) ? 3'b111 : 3'b010, 32'h0});
            rd_src.push_back(vals[i]);
            exp_rdata.push_back(vals[i]);
        end
        run_cmd(1'b0, 32'h200, 5'd3, 0, 0, 1'b1, 100);
        check_end("read3", 1, 0);
        vectors++;
        if (r_rdv != 3) begin
            miscompares++;
            $display("FAIL read3_pulses: got %0d rdata_valid pulses, want 3", r_rdv);
        end
    endtask

    task automatic test_zero_len();
        run_cmd(1'b1, 32'h4000, 5'd0, 0, 0, 1'b1, 20);
        check_end("len0", 1, 0);
        vectors++;
        if (r_done_at != 2 || r_cyc != 0 || r_stb != 0) begin
            miscompares++;
            $display("FAIL len0_timing: got done_at %0d cyc %0d stb %0d, want 2 0 0", r_done_at, r_cyc, r_stb);
        end
    endtask

    task automatic test_write_gap();
        exp_beats.push_back('{32'h300, 3'b010, 32'hCAFE_0001});
        exp_beats.push_back('{32'h304, 3'b111, 32'hCAFE_0002});
        wr_src.push_back(32'hCAFE_0001);
        wr_src.push_back(32'hCAFE_0002);
        run_cmd(1'b1, 32'h300, 5'd2, 5, 1, 1'b1, 100);
        check_end("write_gap", 1, 0);
        vectors++;
        if (r_load != 7) begin
            miscompares++;
            $display("FAIL write_gap_load: got %0d cyc-without-stb cycles, want 7", r_load);
        end
    endtask

    task automatic test_timeout();
        run_cmd(1'b0, 32'h500, 5'd1, 0, 0, 1'b0, 400);
        check_end("timeout", 1, 1);
        vectors++;
        if (r_stb != 256 || r_err_done != 1) begin
            miscompares++;
            $display("FAIL timeout_len: got stb %0d cycles err_with_done %0d, want 256 1", r_stb, r_err_done);
        end
        exp_beats.push_back('{32'h600, 3'b111, 32'h0});
        rd_src.push_back(32'h77);
        exp_rdata.push_back(32'h77);
        run_cmd(1'b0, 32'h600, 5'd1, 0, 0, 1'b1, 50);
        check_end("after_timeout", 1, 0);
    endtask

    task automatic test_reset_mid_burst();
        int acks = 0;
        int bad = 0;
        bit fired = 1'b0;
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h400; cmd_len = 5'd4;
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge sys_clk);
        for (int t = 1; t <= 30 && !fired; t++) begin
            @(negedge sys_clk);
            if (t == 1) cmd_valid = 1'b0;
            if (wb_ack_i) wb_ack_i = 1'b0;
            else if (wb_stb_o && acks == 0) begin
                wb_ack_i = 1'b1;
                wb_dat_i = 32'h99;
                acks = 1;
            end else if (wb_stb_o && acks == 1) begin
                #2 RESETN = 1'b0;
                #1;
                fired = 1'b1;
                vectors++;
                if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL midreset_async: got cyc %b stb %b, want 0 0", wb_cyc_o, wb_stb_o);
                end
            end
        end
        vectors++;
        if (!fired) begin
            miscompares++;
            $display("FAIL midreset_beat2: beat 2 not reached, want reached");
        end
        wb_ack_i = 1'b0;
        repeat (3) begin
            @(negedge sys_clk);
            if (done || err) bad++;
        end
        RESETN = 1'b1;
        repeat (3) begin
            @(negedge sys_clk);
            if (done || err || wb_cyc_o) bad++;
        end
        vectors++;
        if (bad != 0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_after: got %0d done/err/cyc cycles cmd_ready %b, want 0 1", bad, cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_ack_ignored();
        test_write_burst();
        test_read_burst();
        test_zero_len();
        test_write_gap();
        test_timeout();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not end, want finish");
        $fatal(1, "bench timeout");
    end

endmodule
